uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 217, i_clk cycles per UART bit (217 gives 115200 baud at 25 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; legal values power of two, 2..256.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_data  input  8  byte to transmit.
REQ-006 SHALL have port i_valid  input  1  i_data is valid this cycle.
REQ-007 SHALL have port o_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port o_tx  output  1  serial line, idle high, driven from a flop.
REQ-009 SHALL have port o_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL accept a byte into the FIFO on every rising edge where i_valid and o_ready are both high, and ignore i_data otherwise.
REQ-011 SHALL drive o_ready = (FIFO count < FIFO_DEPTH), computed from registered count only, with no combinational path from i_valid.
REQ-012 SHALL, when full, refuse a push even if a pop occurs in the same cycle; a simultaneous push and pop when not full leaves count unchanged.
REQ-013 SHALL implement the shifter FSM states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-014 SHALL, in IDLE with FIFO non-empty, pop one byte and enter START; popping never occurs while empty.
REQ-015 SHALL drive o_tx low for START, data bits LSB-first for DATA (8 bits), and high for STOP, each bit held exactly CLK_DIV cycles.
REQ-016 SHALL drive the first start-bit cycle on o_tx two clock edges after the accepting edge when IDLE and the FIFO is empty.
REQ-017 SHALL, at the end of STOP, pop the next byte and enter START on the same edge if the FIFO is non-empty, giving back-to-back frames with no idle gap; otherwise it enters IDLE.
REQ-018 SHALL use a bit-period counter of width ceil(log2(CLK_DIV)) that reloads at each bit boundary and never wraps mid-bit.
REQ-019 SHALL use a FIFO count of width log2(FIFO_DEPTH)+1, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-020 SHALL deassert o_busy on the same edge the FSM enters IDLE with an empty FIFO.

Reset
REQ-021 SHALL, while i_rst is high, force o_tx=1, o_busy=0, FSM=IDLE, FIFO count and pointers=0, and bit counters=0; o_ready reads 1 on the cycle after reset releases.
REQ-022 SHALL, on i_rst asserted mid-frame, abort the frame with o_tx high on the next edge and discard all FIFO contents.
REQ-023 SHALL not accept a push in any cycle where i_rst is high.

Configuration
REQ-024 SHALL honour macro UART_TX_PARITY_EN: when defined, insert the PARITY state between DATA and STOP, sending the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles, giving an 11-bit frame.
REQ-025 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and logic entirely, giving a 10-bit frame (8N1).

Verification
REQ-026 SHALL cover: CLK_DIV=4, no parity, push 0x55 while idle -> o_tx low on edge 2, then 1,0,1,0,1,0,1,0, then stop=1, each bit 4 cycles, 40 cycles total, o_busy high throughout.
REQ-027 SHALL cover: UART_TX_PARITY_EN defined, CLK_DIV=4, push 0x07 -> data 1,1,1,0,0,0,0,0, parity bit 1, stop 1, 44 cycles total.
REQ-028 SHALL cover: FIFO_DEPTH=4, i_valid held high with bytes 0x01..0x08 -> exactly 5 accepted before o_ready first falls, and frames on o_tx are 0x01..0x05 in order with no idle gap.
REQ-029 SHALL cover: i_rst pulsed 1 cycle during data bit 3 of 0xA5 with 2 bytes queued -> o_tx=1 next edge, o_busy=0, no further frames, and the next push 0x3C is sent correctly.
REQ-030 SHALL cover: push and pop in the same cycle at count=2 -> count stays 2 and byte order is preserved.
REQ-031 SHALL cover: CLK_DIV=2 minimum, push 0xFF and 0x00 back-to-back -> each bit is 2 cycles and both frames are correct.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: byte-wide transmit FIFO feeding an 8-bit LSB-first UART shifter.
// Build macro UART_TX_PARITY_EN adds an even-parity bit between the data and
// stop bits (8E1, 11-bit frame); without it the frame is 8N1 (10 bits).
//
// Handshake: a byte is taken on every rising edge of i_clk where i_valid and
// o_ready are both high and i_rst is low. o_ready depends only on the
// registered FIFO count, so it never combinationally depends on i_valid.
// Once i_valid is raised, i_data must stay stable until the accepting edge.
//
// o_state exposes the shifter FSM encoding for debug and checker binding:
// 0=IDLE 1=START 2=DATA 3=STOP 4=PARITY.
module uart_tx #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic [2:0] o_state
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_ne;

    // Shifter state
    state_t         state;
    state_t         state_n;
    logic [CNT_W-1:0] div_cnt;
    logic           bit_done;
    logic [2:0]     bit_idx;
    logic [7:0]     data_q;
    logic           tx_bit;
    logic           tx_q;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign o_ready  = (count < FULL_CNT);
    assign push     = i_valid && o_ready && !i_rst;
    assign fifo_ne  = (count != '0);
    assign bit_done = (div_cnt == CNT_LAST);

    // FIFO write port; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers wrap naturally modulo the power-of-two depth; count tracks occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state, bit-period counter, data-bit index and the byte being sent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            data_q  <= '0;
        end else begin
            state <= state_n;
            if (pop) data_q <= mem[rd_ptr];
            // Counter runs only inside a frame and reloads on every bit boundary.
            if (state == IDLE || bit_done) div_cnt <= '0;
            else                           div_cnt <= div_cnt + 1'b1;
            if (state != DATA)  bit_idx <= '0;
            else if (bit_done)  bit_idx <= bit_idx + 1'b1;
        end
    end

    // Next-state, pop request and the line level for the current bit.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx_bit  = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_ne) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (bit_done) state_n = DATA;
            end
            DATA: begin
                tx_bit = data_q[bit_idx];
                if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_bit = ^data_q;
                if (bit_done) state_n = STOP;
            end
`endif
            STOP: begin
                tx_bit = 1'b1;
                // Chain straight into the next frame when a byte is waiting.
                if (bit_done) begin
                    if (fifo_ne) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line driver flop: the line lags the FSM by one cycle, and reset forces it idle-high.
    always_ff @(posedge i_clk) begin
        if (i_rst) tx_q <= 1'b1;
        else       tx_q <= tx_bit;
    end

    assign o_tx    = tx_q;
    assign o_busy  = (state != IDLE) || fifo_ne;
    assign o_state = state;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Instance a: CLK_DIV=4, FIFO_DEPTH=4. Instance b: CLK_DIV=2, FIFO_DEPTH=8.
// Frame length follows UART_TX_PARITY_EN (10 bits without, 11 bits with).
module tb_uart_tx;

  localparam int DIV_A   = 4;
  localparam int DEPTH_A = 4;
  localparam int DIV_B   = 2;
  localparam int DEPTH_B = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_A  = NB * DIV_A;
  localparam int POP_EDGE = 1 + FRAME_A;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       a_rst, a_valid, a_ready, a_tx, a_busy;
  logic [7:0] a_data;
  logic [2:0] a_state;
  logic       b_rst, b_valid, b_ready, b_tx, b_busy;
  logic [7:0] b_data;
  logic [2:0] b_state;

  uart_tx #(.CLK_DIV(DIV_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_data(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy), .o_state(a_state)
  );

  uart_tx #(.CLK_DIV(DIV_B), .FIFO_DEPTH(DEPTH_B)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          start_times[$];
  int          frames_seen = 0;
  logic        mon_on = 1'b0;
  int          mon_c = 0;
  logic [10:0] mon_bits = '1;
  logic [7:0]  mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame in transmit order: bit0 = start, bits1..8 = data LSB first,
  // then parity (if enabled) and stop; unused upper bits read as idle-high.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    if (p) return {2'b11, d, 1'b0};
    return {2'b11, d, 1'b0};
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept tracker and line decoder for instance a, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_rst) begin
      exp_q.delete();
      mon_on = 1'b0;
    end else begin
      if (a_valid && a_ready) exp_q.push_back(a_data);
      if (!mon_on && a_tx == 1'b0) begin
        mon_on = 1'b1;
        mon_c  = 0;
        mon_bits = '1;
        start_times.push_back(cyc);
      end
      if (mon_on) begin
        if (mon_c % DIV_A == DIV_A / 2) mon_bits[mon_c / DIV_A] = a_tx;
        if (mon_c == FRAME_A - 1) begin
          mon_on = 1'b0;
          frames_seen++;
          check("frame_was_queued", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("frame_bits", 32'(mon_bits) & ((32'd1 << NB) - 1),
                  32'(frame_of(mon_exp, ^mon_exp)) & ((32'd1 << NB) - 1));
          end
        end else begin
          mon_c++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_valid = 1'b1;
    a_data  = d;
    step();
    a_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input int bound);
    int n = 0;
    while ((a_busy || mon_on) && n < bound) begin
      step();
      n++;
    end
    check("idle_within_bound", 32'(a_busy || mon_on), 32'd0);
    repeat (2) step();
  endtask

  // ---------------- test sequence ----------------
  vec_t        vecs [6];
  logic [10:0] f0, f1;
  logic        exp_bit, exp_busy, will, rose;
  int          bad_tx, bad_busy, fs, n_acc, acc_at_fall, idx, n;

  initial begin
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hA5, 1'b0};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hFE, 1'b1};

    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    repeat (3) step();
    check("rst_tx_a", 32'(a_tx), 32'd1);
    check("rst_busy_a", 32'(a_busy), 32'd0);
    check("rst_tx_b", 32'(b_tx), 32'd1);
    check("rst_busy_b", 32'(b_busy), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    step();
    check("ready_after_rst_a", 32'(a_ready), 32'd1);
    check("ready_after_rst_b", 32'(b_ready), 32'd1);

    // Table: single bytes from idle, exact per-cycle line and busy profile.
    for (int v = 0; v < 6; v++) begin
      wait_idle_a(2000);
      f0 = frame_of(vecs[v].data, vecs[v].par);
      bad_tx = 0;
      bad_busy = 0;
      push_a(vecs[v].data);
      check($sformatf("vec%0d_ready", v), 32'(a_ready), 32'd1);
      for (int k = 0; k <= FRAME_A + 3; k++) begin
        if (k > 0) step();
        exp_bit  = (k >= 2 && k < 2 + FRAME_A) ? f0[(k - 2) / DIV_A] : 1'b1;
        exp_busy = (k <= FRAME_A);
        if (a_tx !== exp_bit) bad_tx++;
        if (a_busy !== exp_busy) bad_busy++;
      end
      check($sformatf("vec%0d_tx_cycles_wrong", v), 32'(bad_tx), 32'd0);
      check($sformatf("vec%0d_busy_cycles_wrong", v), 32'(bad_busy), 32'd0);
    end

    // Fill a 4-deep FIFO with i_valid held: 5 accepted before o_ready falls.
    wait_idle_a(2000);
    fs = frames_seen;
    start_times.delete();
    a_valid = 1'b1; a_data = 8'h01;
    n_acc = 0; acc_at_fall = -1; rose = 1'b0;
    for (int c = 0; c < 400 && !rose; c++) begin
      will = a_ready;
      step();
      if (will) begin
        n_acc++;
        a_data = a_data + 8'd1;
      end
      if (!a_ready && acc_at_fall < 0) acc_at_fall = n_acc;
      if (a_ready && acc_at_fall >= 0) rose = 1'b1;
    end
    a_valid = 1'b0;
    check("fill_ready_rose", 32'(rose), 32'd1);
    check("fill_accepted_at_fall", 32'(acc_at_fall), 32'd5);
    check("fill_accepted_total", 32'(n_acc), 32'd5);
    wait_idle_a(8000);
    check("fill_frames", 32'(frames_seen - fs), 32'd5);
    check("fill_starts", 32'(start_times.size()), 32'd5);
    for (int i = 1; i < start_times.size(); i++)
      check($sformatf("fill_gap%0d", i), 32'(start_times[i] - start_times[i-1]), 32'(FRAME_A));

    // Push and pop on the same edge at count=2.
    wait_idle_a(2000);
    fs = frames_seen;
    a_valid = 1'b1; a_data = 8'h31; step();
    a_data = 8'h32; step();
    a_data = 8'h33; step();
    a_valid = 1'b0;
    repeat (POP_EDGE - 3) step();
    a_valid = 1'b1; a_data = 8'h34; step();
    a_data = 8'h35; step();
    check("pp_ready_at_3", 32'(a_ready), 32'd1);
    a_data = 8'h36; step();
    check("pp_ready_at_4", 32'(a_ready), 32'd0);
    a_valid = 1'b0;
    wait_idle_a(8000);
    check("pp_frames", 32'(frames_seen - fs), 32'd6);

    // Reset pulse during data bit 3 of 0xA5 with two bytes queued.
    wait_idle_a(2000);
    fs = frames_seen;
    a_valid = 1'b1; a_data = 8'hA5; step();
    a_data = 8'h11; step();
    a_data = 8'h22; step();
    a_valid = 1'b0;
    repeat (16) step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    check("midrst_tx", 32'(a_tx), 32'd1);
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd1);
    bad_tx = 0;
    for (int k = 0; k < 120; k++) begin
      step();
      if (a_tx !== 1'b1 || a_busy !== 1'b0) bad_tx++;
    end
    check("midrst_quiet_cycles_wrong", 32'(bad_tx), 32'd0);
    check("midrst_no_frames", 32'(frames_seen - fs), 32'd0);
    push_a(8'h3C);
    wait_idle_a(2000);
    check("midrst_recover_frames", 32'(frames_seen - fs), 32'd1);

    // CLK_DIV=2: 0xFF then 0x00 back-to-back, exact per-cycle line.
    f0 = frame_of(8'hFF, 1'b0);
    f1 = frame_of(8'h00, 1'b0);
    bad_tx = 0;
    bad_busy = 0;
    b_valid = 1'b1; b_data = 8'hFF; step();
    b_data = 8'h00; step();
    b_valid = 1'b0;
    for (int k = 1; k <= 2 * NB * DIV_B + 4; k++) begin
      if (k > 1) step();
      exp_bit = 1'b1;
      if (k >= 2 && k < 2 + 2 * NB * DIV_B) begin
        idx = (k - 2) / DIV_B;
        exp_bit = (idx < NB) ? f0[idx] : f1[idx - NB];
      end
      exp_busy = (k <= 2 * NB * DIV_B);
      if (b_tx !== exp_bit) bad_tx++;
      if (b_busy !== exp_busy) bad_busy++;
    end
    check("div2_tx_cycles_wrong", 32'(bad_tx), 32'd0);
    check("div2_busy_cycles_wrong", 32'(bad_busy), 32'd0);

    // Randomized traffic with random gaps; the decoder checks every frame.
    wait_idle_a(2000);
    fs = frames_seen;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 60)) step();
      a_data = 8'($urandom);
      a_valid = 1'b1;
      n = 0;
      while (!a_ready && n < 1000) begin
        step();
        n++;
      end
      check("rand_ready_within_bound", 32'(a_ready), 32'd1);
      step();
      a_valid = 1'b0;
    end
    wait_idle_a(20000);
    check("rand_frames", 32'(frames_seen - fs), 32'd30);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
